// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data cache controller with pipelined line fill
// Hit paths are combinational; a miss walks the line from word 0 with in-order returns.
module dcache_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 16,
    parameter int WORDS_PER_LINE = 8,
    parameter int NUM_LINES      = 64,
    parameter int WRITE_ALLOC    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op,
    input  logic              write,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              invalidate,
    output logic [DATA_W-1:0] data_out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;

    generate
        if (ADDR_W <= 1 + OFF_W + IDX_W) begin : g_bad_geometry
            $error("dcache_ctrl: ADDR_W too small for line/index geometry");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                  state;
    logic [OFF_W:0]          issue_cnt;
    logic [OFF_W-1:0]        ret_cnt;
    logic [TAG_W-1:0]        fill_tag;
    logic [IDX_W-1:0]        fill_idx;
    logic [NUM_LINES-1:0]    valid;
    logic [TAG_W-1:0]        tag_mem  [NUM_LINES];
    logic [DATA_W-1:0]       data_mem [NUM_LINES*WORDS_PER_LINE];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             start_fill;
    logic             fill_done;
    logic             hit_write;
    logic             unused_bit0;

    assign off         = address_in[OFF_W:1];
    assign idx         = address_in[OFF_W+IDX_W:OFF_W+1];
    assign tag         = address_in[ADDR_W-1:OFF_W+IDX_W+1];
    assign unused_bit0 = address_in[0];

    assign hit        = op & valid[idx] & (tag_mem[idx] == tag);
    assign start_fill = (state == S_IDLE) & op & ~hit & (~write | (WRITE_ALLOC != 0));
    assign fill_done  = (state == S_FILL) & mem_rvalid & (&ret_cnt);
    assign hit_write  = (state == S_IDLE) & op & write & hit & mem_ready;

    always_comb begin
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        data_out  = '0;
        if (state == S_FILL) begin
            stall = 1'b1;
            // issue_cnt MSB set means every word of the line has been requested
            if (!issue_cnt[OFF_W]) begin
                mem_req  = 1'b1;
                mem_addr = {fill_tag, fill_idx, issue_cnt[OFF_W-1:0], 1'b0};
            end
        end else if (op) begin
            if (!write) begin
                if (hit) data_out = data_mem[{idx, off}];
                else     stall    = 1'b1;
            end else if ((WRITE_ALLOC != 0) && !hit) begin
                stall = 1'b1;
            end else begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = address_in;
                mem_wdata = data_in;
                stall     = ~mem_ready;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            fill_tag  <= '0;
            fill_idx  <= '0;
            valid     <= '0;
        end else begin
            if (invalidate) valid <= '0;
            case (state)
                S_IDLE: begin
                    if (start_fill) begin
                        state         <= S_FILL;
                        fill_tag      <= tag;
                        fill_idx      <= idx;
                        // the line is overwritten in place, so it must not hit mid-fill
                        valid[idx]    <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (mem_req && mem_ready) issue_cnt <= issue_cnt + 1'b1;
                    if (mem_rvalid) ret_cnt <= ret_cnt + 1'b1;
                    if (fill_done) begin
                        valid[fill_idx] <= 1'b1;
                        issue_cnt       <= '0;
                        ret_cnt         <= '0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == S_FILL) && mem_rvalid) data_mem[{fill_idx, ret_cnt}] <= mem_rdata;
        if (hit_write) data_mem[{idx, off}] <= data_in;
        if (fill_done) tag_mem[fill_idx] <= fill_tag;
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed bench for dcache_ctrl, no-allocate and write-allocate instances
// Memory model: 4-cycle read latency, in-order returns, initial word = byte address ^ 0xA5A5.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_v [2];
    logic        write = 1'b0;
    logic [15:0] address_in = '0;
    logic [15:0] data_in = '0;
    logic        invalidate = 1'b0;
    logic        mem_ready = 1'b1;

    logic [15:0] dout_v  [2];
    logic        stall_v [2];
    logic        req_v   [2];
    logic        we_v    [2];
    logic [15:0] addr_v  [2];
    logic [15:0] wdata_v [2];
    logic [15:0] rdata_v [2];
    logic        rvalid_v[2];

    logic [15:0] mem [0:32767];
    logic [3:0]  pv [2];
    logic [15:0] pd [2][4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_ctrl #(.WRITE_ALLOC(0)) u_na (
        .clk(clk), .rst(rst), .op(op_v[0]), .write(write), .address_in(address_in),
        .data_in(data_in), .invalidate(invalidate), .data_out(dout_v[0]), .stall(stall_v[0]),
        .mem_req(req_v[0]), .mem_we(we_v[0]), .mem_addr(addr_v[0]), .mem_wdata(wdata_v[0]),
        .mem_ready(mem_ready), .mem_rdata(rdata_v[0]), .mem_rvalid(rvalid_v[0])
    );

    dcache_ctrl #(.WRITE_ALLOC(1)) u_wa (
        .clk(clk), .rst(rst), .op(op_v[1]), .write(write), .address_in(address_in),
        .data_in(data_in), .invalidate(invalidate), .data_out(dout_v[1]), .stall(stall_v[1]),
        .mem_req(req_v[1]), .mem_we(we_v[1]), .mem_addr(addr_v[1]), .mem_wdata(wdata_v[1]),
        .mem_ready(mem_ready), .mem_rdata(rdata_v[1]), .mem_rvalid(rvalid_v[1])
    );

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rvalid_v[p] = pv[p][3];
            rdata_v[p]  = pd[p][3];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < 2; p++) pv[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                pv[p]    <= {pv[p][2:0], req_v[p] & mem_ready & ~we_v[p]};
                pd[p][0] <= mem[addr_v[p][15:1]];
                pd[p][1] <= pd[p][0];
                pd[p][2] <= pd[p][1];
                pd[p][3] <= pd[p][2];
                if (req_v[p] && mem_ready && we_v[p]) mem[addr_v[p][15:1]] <= wdata_v[p];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input int p, input string tag);
        int n;
        n = 0;
        while (stall_v[p] && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_fill_done"}, 32'(n < 60), 32'd1);
    endtask

    initial begin
        int n_stall;
        int n_reads;
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 2) ^ 16'hA5A5;
        op_v[0] = 1'b0;
        op_v[1] = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", 32'(stall_v[0]), 0);
        check("rst_req_we", {30'd0, req_v[0], we_v[0]}, 0);
        check("rst_addr", 32'(addr_v[0]), 0);
        check("rst_wdata", 32'(wdata_v[0]), 0);
        check("rst_dout", 32'(dout_v[0]), 0);
        next_cycle();
        rst = 1'b1;

        // read miss at 0x0040 with full fill timing
        next_cycle();
        op_v[0] = 1'b1; write = 1'b0; address_in = 16'h0040;
        #1;
        n_stall = 0;
        for (int c = 0; c < 14; c++) begin
            if (stall_v[0]) n_stall++;
            if (c == 0) check("miss_c0_noreq", 32'(req_v[0]), 0);
            if (c >= 1 && c <= 8)
                check($sformatf("issue_c%0d", c), {15'd0, req_v[0], addr_v[0]},
                      {15'd0, 1'b1, 16'(16'h0040 + 2 * (c - 1))});
            if (c < 13) begin
                next_cycle();
                #1;
            end
        end
        check("miss_stall_cycles", 32'(n_stall), 13);
        check("miss_c13_stall", 32'(stall_v[0]), 0);
        check("miss_c13_data", 32'(dout_v[0]), 32'hA5E5);

        // read hit in same line
        next_cycle();
        address_in = 16'h004A;
        #1;
        check("hit_data", 32'(dout_v[0]), 32'hA5EF);
        check("hit_stall", 32'(stall_v[0]), 0);
        check("hit_noreq", 32'(req_v[0]), 0);

        // write hit with two not-ready cycles
        next_cycle();
        write = 1'b1; address_in = 16'h0044; data_in = 16'hBEEF; mem_ready = 1'b0;
        #1;
        check("wr_wait1_stall", 32'(stall_v[0]), 1);
        check("wr_wait1_req_we", {30'd0, req_v[0], we_v[0]}, 3);
        next_cycle();
        #1;
        check("wr_wait2_stall", 32'(stall_v[0]), 1);
        next_cycle();
        mem_ready = 1'b1;
        #1;
        check("wr_accept_stall", 32'(stall_v[0]), 0);
        check("wr_accept_addr", 32'(addr_v[0]), 32'h0044);
        check("wr_accept_wdata", 32'(wdata_v[0]), 32'hBEEF);
        next_cycle();
        write = 1'b0;
        #1;
        check("wr_readback", 32'(dout_v[0]), 32'hBEEF);
        check("wr_readback_stall", 32'(stall_v[0]), 0);

        // write miss, no allocate
        next_cycle();
        write = 1'b1; address_in = 16'h8000; data_in = 16'h1234;
        #1;
        check("wmiss_stall", 32'(stall_v[0]), 0);
        check("wmiss_req_we", {30'd0, req_v[0], we_v[0]}, 3);
        check("wmiss_addr", 32'(addr_v[0]), 32'h8000);
        next_cycle();
        write = 1'b0;
        #1;
        check("wmiss_line_invalid", 32'(stall_v[0]), 1);
        run_fill(0, "wmiss");
        check("wmiss_mem_data", 32'(dout_v[0]), 32'h1234);

        // write miss, write-allocate instance
        next_cycle();
        op_v[0] = 1'b0; op_v[1] = 1'b1;
        write = 1'b1; address_in = 16'h8000; data_in = 16'h5678;
        #1;
        n_stall = 0;
        n_reads = 0;
        for (int c = 0; c < 60; c++) begin
            if (!stall_v[1]) break;
            n_stall++;
            if (req_v[1] && !we_v[1]) n_reads++;
            next_cycle();
            #1;
        end
        check("wa_stall_cycles", 32'(n_stall), 13);
        check("wa_fill_reads", 32'(n_reads), 8);
        check("wa_write_req_we", {30'd0, req_v[1], we_v[1]}, 3);
        check("wa_write_addr", 32'(addr_v[1]), 32'h8000);
        check("wa_write_wdata", 32'(wdata_v[1]), 32'h5678);
        next_cycle();
        write = 1'b0;
        #1;
        check("wa_read_stall", 32'(stall_v[1]), 0);
        check("wa_read_data", 32'(dout_v[1]), 32'h5678);

        // conflict: same index, different tag
        next_cycle();
        op_v[1] = 1'b0; op_v[0] = 1'b1; address_in = 16'h4040;
        #1;
        check("conf_miss", 32'(stall_v[0]), 1);
        run_fill(0, "conf1");
        check("conf_data", 32'(dout_v[0]), 32'hE5E5);
        next_cycle();
        address_in = 16'h0040;
        #1;
        check("conf_remiss", 32'(stall_v[0]), 1);
        run_fill(0, "conf2");
        check("conf_redata", 32'(dout_v[0]), 32'hA5E5);

        // invalidate then read misses
        next_cycle();
        op_v[0] = 1'b0; invalidate = 1'b1;
        next_cycle();
        invalidate = 1'b0; op_v[0] = 1'b1;
        #1;
        check("inv_miss", 32'(stall_v[0]), 1);

        // reset at fill cycle 5
        repeat (5) next_cycle();
        rst = 1'b0; op_v[0] = 1'b0;
        #1;
        check("midrst_stall", 32'(stall_v[0]), 0);
        check("midrst_req_we", {30'd0, req_v[0], we_v[0]}, 0);
        check("midrst_addr", 32'(addr_v[0]), 0);
        check("midrst_dout", 32'(dout_v[0]), 0);
        next_cycle();
        rst = 1'b1; op_v[0] = 1'b1;
        #1;
        check("midrst_remiss", 32'(stall_v[0]), 1);
        run_fill(0, "midrst");
        check("midrst_data", 32'(dout_v[0]), 32'hA5E5);

        next_cycle();
        op_v[0] = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
